// File: rtl/prince_cms_compress_pkg.sv
// Shared constants and helpers for the PRINCE three-share compression stage.
// NTERMS  : cross-share product terms per S-box output bit (3 shares, degree 3)
// NPART   : number of refreshed partial sums per output bit
// NSHARES : number of output shares
// ringNext: index of the neighbouring mask in the ring of NPART masks
package prince_cms_pkg;

  localparam int NTERMS  = 27;
  localparam int NPART   = 9;
  localparam int NSHARES = 3;

  // Each partial is masked by its own mask and its ring neighbour, so every
  // mask appears in exactly two partials and cancels in the share sum.
  function automatic int ringNext(input int j);
    return (j + 1) % NPART;
  endfunction

endpackage

// File: rtl/prince_cms_compress_if.sv
// Handshake bundle between the S-box term stage, the compression block and
// its consumer.
// master: drives in_valid, terms, rnd, out_ready; observes in_ready,
//         out_valid and the three output shares.
// slave : the compression block itself (mirror of master).
interface prince_cms_compress_if #(
  parameter int WIDTH  = 4,
  parameter int NTERMS = 27
);

  logic                                    in_valid;
  logic                                    in_ready;
  logic [WIDTH*NTERMS-1:0]                 terms;
  logic [WIDTH*prince_cms_pkg::NPART-1:0]  rnd;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [WIDTH-1:0]                        out_share0;
  logic [WIDTH-1:0]                        out_share1;
  logic [WIDTH-1:0]                        out_share2;

  modport master (
    output in_valid, terms, rnd, out_ready,
    input  in_ready, out_valid, out_share0, out_share1, out_share2
  );

  modport slave (
    input  in_valid, terms, rnd, out_ready,
    output in_ready, out_valid, out_share0, out_share1, out_share2
  );

endinterface

// File: rtl/prince_cms_compress_refresh.sv
// Per-bit term grouping and refresh: folds 27 product terms into 9 partial
// sums, each masked by two neighbouring fresh random bits.
// terms_i : 27 product terms of one S-box output bit (term k at bit k)
// rnd_i   : 9 fresh mask bits r[0..8]
// part_o  : 9 combinational partials p[0..8], registered by the parent
module prince_cms_refresh
  import prince_cms_pkg::*;
(
  input  logic [NTERMS-1:0] terms_i,
  input  logic [NPART-1:0]  rnd_i,
  output logic [NPART-1:0]  part_o
);

  // Only terms of the same group of three are combined here; mixing across
  // groups happens after the parent's register stage.
  for (genvar j = 0; j < NPART; j++) begin : g_part
    assign part_o[j] = terms_i[3*j] ^ terms_i[3*j+1] ^ terms_i[3*j+2]
                     ^ rnd_i[j] ^ rnd_i[ringNext(j)];
  end

endmodule

// File: rtl/prince_cms_compress.sv
// Two-stage masked compression for a 3-share PRINCE S-box.
// Stage 1 registers 9 refreshed partials per bit (glitch barrier), stage 2
// XORs groups of three partials into the output shares.
// clk : rising-edge clock
// rst : synchronous active-high reset, clears valids and data registers
// bus : slave side of prince_cms_compress_if (in/out valid-ready handshake,
//       terms, rnd, out_share0..2)
module prince_cms_compress #(
  parameter int WIDTH  = 4,
  parameter int NTERMS = 27
) (
  input logic                   clk,
  input logic                   rst,
  prince_cms_compress_if.slave  bus
);
  import prince_cms_pkg::*;

  logic                    stall;
  logic                    v1_q;
  logic                    v2_q;
  logic [WIDTH*NPART-1:0]  p_d;
  logic [WIDTH*NPART-1:0]  p_q;
  logic [WIDTH-1:0]        share0_d, share1_d, share2_d;
  logic [WIDTH-1:0]        share0_q, share1_q, share2_q;

  // The pipeline only blocks when a finished result cannot leave.
  assign stall        = v2_q & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    prince_cms_refresh u_refresh (
      .terms_i (bus.terms[b*NTERMS +: NTERMS]),
      .rnd_i   (bus.rnd[b*NPART +: NPART]),
      .part_o  (p_d[b*NPART +: NPART])
    );
  end

  // Compression reads only registered partials, so no unregistered terms
  // from different groups ever meet in one XOR tree.
  always_comb begin
    share0_d = '0;
    share1_d = '0;
    share2_d = '0;
    for (int b = 0; b < WIDTH; b++) begin
      share0_d[b] = ^p_q[b*NPART + 0 +: 3];
      share1_d[b] = ^p_q[b*NPART + 3 +: 3];
      share2_d[b] = ^p_q[b*NPART + 6 +: 3];
    end
  end

  // Data registers load only alongside a set valid so bubbles never clobber
  // held data; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      p_q      <= '0;
      share0_q <= '0;
      share1_q <= '0;
      share2_q <= '0;
    end else if (!stall) begin
      v2_q <= v1_q;
      if (v1_q) begin
        share0_q <= share0_d;
        share1_q <= share1_d;
        share2_q <= share2_d;
      end
      v1_q <= bus.in_valid;
      if (bus.in_valid) begin
        p_q <= p_d;
      end
    end
  end

  assign bus.out_valid  = v2_q;
  assign bus.out_share0 = share0_q;
  assign bus.out_share1 = share1_q;
  assign bus.out_share2 = share2_q;

endmodule
